// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter slice.
//   N_REQ / IDX_W : requester count and binary index width
//   arbState_t    : arbiter FSM encoding (IDLE / GRANT)
//   encoder83     : one-hot to 3-bit binary index encoder
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arbState_t;

    // OR-reduction encoder: correct for any one-hot (or zero) input, no priority chain.
    function automatic logic [IDX_W-1:0] encoder83(input logic [N_REQ-1:0] oneHot);
        logic [IDX_W-1:0] enc;
        enc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oneHot[i]) begin
                enc = enc | IDX_W'(i);
            end
        end
        return enc;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and rr_arbiter8.
//   iReq     : level request, bit k = requester k
//   oGnt     : registered one-hot grant
//   oIdx     : binary index of the granted requester
//   oValid   : a grant is currently held
//   oTimeout : one-cycle pulse when the previous owner was cut off by the hold limit
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic [N_REQ-1:0] iReq;
    logic [N_REQ-1:0] oGnt;
    logic [IDX_W-1:0] oIdx;
    logic             oValid;
    logic             oTimeout;

    modport master (output iReq, input  oGnt, oIdx, oValid, oTimeout);
    modport slave  (input  iReq, output oGnt, oIdx, oValid, oTimeout);

endinterface

// File: rtl/rr_arbiter8_pick.sv
// rr_pick8: combinational round-robin pick.
//   req     : request vector
//   ptr     : index that currently has highest priority
//   nextGnt : one-hot winner (first set bit scanning ptr, ptr+1, ... mod 8)
//   anyReq  : at least one request is set
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] nextGnt,
    output logic             anyReq
);

    logic [2*N_REQ-1:0] rotDbl;
    logic [2*N_REQ-1:0] backDbl;
    logic [N_REQ-1:0]   rotReq;
    logic [N_REQ-1:0]   lowest;

    // Rotate right by ptr so that requester ptr lands in bit 0.
    assign rotDbl  = {req, req} >> ptr;
    assign rotReq  = rotDbl[N_REQ-1:0];
    // Isolate the lowest set bit (two's complement trick).
    assign lowest  = rotReq & N_REQ'(~rotReq + N_REQ'(1));
    // Rotate left by ptr; the upper half of the doubled word holds the wrapped result.
    assign backDbl = {lowest, lowest} << ptr;
    assign nextGnt = backDbl[2*N_REQ-1:N_REQ];
    assign anyReq  = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one resource among 8 requesters,
// with a bounded hold time so no owner can starve the others.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : rr_arbiter8_if.slave (iReq in; oGnt, oIdx, oValid, oTimeout out)
// HOLD_MAX : max consecutive cycles one owner may hold the grant, 0 = unlimited (0..255).
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);

    localparam bit         LIMITED  = (HOLD_MAX != 0);
    localparam logic [7:0] CNT_LAST = 8'(LIMITED ? HOLD_MAX - 1 : 0);

    arbState_t        state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       cnt;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             timeout;

    logic [N_REQ-1:0] nextGnt;
    logic             anyReq;
    logic [IDX_W-1:0] nextIdx;
    logic             releaseNow;
    logic             expireNow;
    logic             endNow;

    rr_pick8 uPick (
        .req     (bus.iReq),
        .ptr     (ptr),
        .nextGnt (nextGnt),
        .anyReq  (anyReq)
    );

    assign nextIdx = encoder83(nextGnt);

    // Only the owner's own request bit is watched while granted.
    assign releaseNow = (state == ST_GRANT) && !bus.iReq[idx];
    assign expireNow  = (state == ST_GRANT) && LIMITED && (cnt == CNT_LAST);
    assign endNow     = releaseNow || expireNow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            // A simultaneous release wins over expiry, so no timeout is flagged then.
            timeout <= expireNow && !releaseNow;
            if ((state == ST_IDLE) || endNow) begin
                if (anyReq) begin
                    state <= ST_GRANT;
                    gnt   <= nextGnt;
                    idx   <= nextIdx;
                    valid <= 1'b1;
                    ptr   <= nextIdx + IDX_W'(1);   // served owner drops to lowest priority
                    cnt   <= '0;
                end else begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    idx   <= '0;
                    valid <= 1'b0;
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign bus.oGnt     = gnt;
    assign bus.oIdx     = idx;
    assign bus.oValid   = valid;
    assign bus.oTimeout = timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (hold limit 4 and unlimited) share one
// request vector; a queue-free owner/pointer model computes the expected outputs.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;

    always #5 clk = ~clk;

    rr_arbiter8_if busA ();
    rr_arbiter8_if busB ();

    assign busA.iReq = req;
    assign busB.iReq = req;

    rr_arbiter8 #(.HOLD_MAX(4)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
    rr_arbiter8 #(.HOLD_MAX(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

    int nVec  = 0;
    int nFail = 0;

    // Model state per instance: 0 = hold limit 4, 1 = unlimited.
    int mHold  [2] = '{4, 0};
    int mOwner [2];     // -1 when nobody owns the resource
    int mPtr   [2];
    int mHeld  [2];     // completed cycles of the current tenure
    int mTmo   [2];

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic modelEdge(input logic [7:0] r, input logic rn);
        for (int m = 0; m < 2; m++) begin
            if (!rn) begin
                mOwner[m] = -1; mPtr[m] = 0; mHeld[m] = 0; mTmo[m] = 0;
            end else begin
                bit rel, exp;
                rel = (mOwner[m] >= 0) && !r[mOwner[m]];
                exp = (mOwner[m] >= 0) && (mHold[m] != 0) && (mHeld[m] + 1 == mHold[m]);
                mTmo[m] = (exp && !rel) ? 1 : 0;
                if (mOwner[m] < 0 || rel || exp) begin
                    int win;
                    win = -1;
                    for (int j = 0; j < 8; j++) begin
                        if (win < 0 && r[(mPtr[m] + j) % 8]) win = (mPtr[m] + j) % 8;
                    end
                    mOwner[m] = win;
                    mHeld[m]  = 0;
                    if (win >= 0) mPtr[m] = (win + 1) % 8;
                end else begin
                    mHeld[m]++;
                end
            end
        end
    endtask

    task automatic compareAll();
        for (int m = 0; m < 2; m++) begin
            int eG, eI, eV;
            int aG, aI, aV, aT;
            eG = (mOwner[m] < 0) ? 0 : (1 << mOwner[m]);
            eI = (mOwner[m] < 0) ? 0 : mOwner[m];
            eV = (mOwner[m] < 0) ? 0 : 1;
            aG = (m == 0) ? int'(busA.oGnt)     : int'(busB.oGnt);
            aI = (m == 0) ? int'(busA.oIdx)     : int'(busB.oIdx);
            aV = (m == 0) ? int'(busA.oValid)   : int'(busB.oValid);
            aT = (m == 0) ? int'(busA.oTimeout) : int'(busB.oTimeout);
            chk((m == 0) ? "A.oGnt" : "B.oGnt", aG, eG);
            chk((m == 0) ? "A.oIdx" : "B.oIdx", aI, eI);
            chk((m == 0) ? "A.oValid" : "B.oValid", aV, eV);
            chk((m == 0) ? "A.oTimeout" : "B.oTimeout", aT, mTmo[m]);
        end
    endtask

    // Apply inputs, take one edge, advance the model, then check #1 later.
    task automatic cycle(input logic [7:0] r, input logic rn);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        modelEdge(r, rn);
        #1;
        compareAll();
    endtask

    initial begin
        // Reset and first grant
        cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b0);
        chk("rst oGnt", int'(busA.oGnt), 0);
        chk("rst oValid", int'(busA.oValid), 0);
        cycle(8'h04, 1'b1);
        chk("s1 oGnt", int'(busA.oGnt), 8'h04);
        chk("s1 oIdx", int'(busA.oIdx), 2);
        chk("s1 oValid", int'(busA.oValid), 1);
        cycle(8'h00, 1'b1);
        chk("s1 idle oValid", int'(busA.oValid), 0);

        // All requesting: rotation in blocks of 4, timeout on every hand-over
        cycle(8'hFF, 1'b0);
        for (int c = 0; c < 33; c++) begin
            cycle(8'hFF, 1'b1);
            chk("s2 A.oIdx", int'(busA.oIdx), (c / 4) % 8);
            chk("s2 A.oTimeout", int'(busA.oTimeout), (c > 0 && c % 4 == 0) ? 1 : 0);
            chk("s2 B.oIdx", int'(busB.oIdx), 0);
        end

        // Release hand-over by pointer order
        cycle(8'h00, 1'b0);
        cycle(8'h08, 1'b1);
        chk("s3 owner3", int'(busA.oIdx), 3);
        cycle(8'h22, 1'b1);
        chk("s3 oIdx5", int'(busA.oIdx), 5);
        chk("s3 oTimeout", int'(busA.oTimeout), 0);
        cycle(8'h02, 1'b1);
        chk("s3 oIdx1", int'(busA.oIdx), 1);
        chk("s3 oTimeout2", int'(busA.oTimeout), 0);

        // Lone requester re-granted on expiry
        cycle(8'h00, 1'b0);
        for (int c = 0; c < 12; c++) begin
            cycle(8'h80, 1'b1);
            chk("s4 oGnt", int'(busA.oGnt), 8'h80);
            chk("s4 oValid", int'(busA.oValid), 1);
            chk("s4 oTimeout", int'(busA.oTimeout), (c > 0 && c % 4 == 0) ? 1 : 0);
        end

        // Reset in the middle of a grant
        cycle(8'h00, 1'b0);
        cycle(8'h40, 1'b1);
        cycle(8'h40, 1'b1);
        chk("s5 owner6", int'(busA.oIdx), 6);
        cycle(8'h41, 1'b0);
        chk("s5 rst oGnt", int'(busA.oGnt), 0);
        chk("s5 rst oValid", int'(busA.oValid), 0);
        cycle(8'h41, 1'b1);
        chk("s5 oIdx0", int'(busA.oIdx), 0);

        // Unlimited hold
        cycle(8'h00, 1'b0);
        for (int c = 0; c < 20; c++) begin
            cycle(8'h03, 1'b1);
            chk("s6 B.oIdx", int'(busB.oIdx), 0);
            chk("s6 B.oTimeout", int'(busB.oTimeout), 0);
        end
        cycle(8'h02, 1'b1);
        chk("s6 B.oIdx1", int'(busB.oIdx), 1);
        cycle(8'h00, 1'b1);
        chk("s6 B.oValid", int'(busB.oValid), 0);
        chk("s6 B.oIdx", int'(busB.oIdx), 0);

        // Randomized traffic with slowly changing requests and rare resets
        begin
            logic [7:0] r;
            r = 8'h00;
            for (int c = 0; c < 3000; c++) begin
                case ($urandom_range(0, 9))
                    0:       r = 8'($urandom);
                    1, 2:    r = r ^ (8'h01 << $urandom_range(0, 7));
                    3:       r = 8'h00;
                    default: r = r;
                endcase
                cycle(r, ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
